// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: key synchronisation and debounce, press-event
// generation, start/pause/lap/reset state machine, centisecond prescaler.
// The downstream counter increments on tick, clears on cnt_clr, and the
// display shows the latched lap value while disp_hold is high.
module stopwatch_ctrl #(
    parameter int DIV = 500000,   // clk cycles per tick, >= 2
    parameter int DEB = 1000000   // stable cycles to accept a key level, >= 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       pow,
    input  logic       key_str,
    input  logic       key_pas,
    input  logic       key_lap,
    output logic       tick,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       run_led
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEB - 1);

    // Key bit positions inside the per-key vectors below.
    localparam int K_STR = 0;
    localparam int K_PAS = 1;
    localparam int K_LAP = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_STR,
        EV_PAS,
        EV_LAP
    } event_t;

    state_t        st;
    event_t        ev;
    logic [2:0]    key_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    press;
    logic [DW-1:0] deb_cnt [3];
    logic [PW-1:0] presc;
    logic          running;

    assign key_raw = {key_lap, key_pas, key_str};
    assign running = (st == RUN) || (st == LAP);

    // Synchronise the keys, debounce each one and register its press pulse.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of its neighbour; blocking would collapse the
            // two synchroniser stages into one.
            sync1 <= key_raw;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Pick the single press event acted on this cycle: pas > str > lap.
    always_comb begin
        // NOTE: default first so no path through the ifs leaves ev unassigned,
        // which would otherwise infer a latch.
        ev = EV_NONE;
        if (pow) begin
            if (press[K_PAS])      ev = EV_PAS;
            else if (press[K_STR]) ev = EV_STR;
            else if (press[K_LAP]) ev = EV_LAP;
        end
    end

    // Start/pause/lap/reset state machine with registered side outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st        <= IDLE;
            cnt_clr   <= 1'b0;
            disp_hold <= 1'b0;
        end else begin
            cnt_clr <= 1'b0;
            if (!pow) begin
                st        <= IDLE;
                disp_hold <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (ev == EV_STR)      st <= RUN;
                        else if (ev == EV_LAP) cnt_clr <= 1'b1;
                    end
                    RUN: begin
                        if (ev == EV_PAS) begin
                            st <= PAUSE;
                        end else if (ev == EV_LAP) begin
                            st        <= LAP;
                            disp_hold <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (ev == EV_LAP) begin
                            st        <= RUN;
                            disp_hold <= 1'b0;
                        end else if (ev == EV_PAS) begin
                            st        <= PAUSE;
                            disp_hold <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (ev == EV_STR) begin
                            st <= RUN;
                        end else if (ev == EV_LAP) begin
                            st      <= IDLE;
                            cnt_clr <= 1'b1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Prescaler: counts while running, holds in PAUSE, cleared in IDLE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc <= '0;
        end else if (running) begin
            presc <= (presc == PS_LAST) ? '0 : presc + PW'(1);
        end else if (st == IDLE || cnt_clr) begin
            presc <= '0;
        end
    end

    assign tick    = running && (presc == PS_LAST);
    assign run_led = running;
    assign state   = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus randomized key/pow
// activity, every cycle compared against a behavioural reference model.
module tb_stopwatch_ctrl;

    localparam int DIV = 5;
    localparam int DEB = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_LAP   = 2;
    localparam int S_PAUSE = 3;

    // Key masks: bit0 start, bit1 pause, bit2 lap.
    localparam bit [2:0] M_STR = 3'b001;
    localparam bit [2:0] M_PAS = 3'b010;
    localparam bit [2:0] M_LAP = 3'b100;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       pow = 1'b1;
    logic       key_str = 1'b1;
    logic       key_pas = 1'b1;
    logic       key_lap = 1'b1;
    logic       tick;
    logic       cnt_clr;
    logic       disp_hold;
    logic [1:0] state;
    logic       run_led;

    stopwatch_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
        .clk       (clk),
        .clr       (clr),
        .pow       (pow),
        .key_str   (key_str),
        .key_pas   (key_pas),
        .key_lap   (key_lap),
        .tick      (tick),
        .cnt_clr   (cnt_clr),
        .disp_hold (disp_hold),
        .state     (state),
        .run_led   (run_led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tick_cnt = 0;
    int clr_cnt  = 0;

    // Reference model. Keys are indexed 0 start, 1 pause, 2 lap.
    int m_state;
    int m_phase;             // cycles spent running, modulo DIV
    bit m_clr;
    bit m_acc  [3];          // accepted (debounced) key level
    int m_run  [3];          // consecutive cycles seen level != accepted
    bit m_h1   [3];          // raw key one edge ago
    bit m_h2   [3];          // raw key two edges ago
    bit m_fell1[3];          // accepted level fell one edge ago
    bit m_fell2[3];          // accepted level fell two edges ago

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_phase = 0;
        m_clr   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 1'b1;
            m_run[k]   = 0;
            m_h1[k]    = 1'b1;
            m_h2[k]    = 1'b1;
            m_fell1[k] = 1'b0;
            m_fell2[k] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_step();
        bit raw  [3];
        bit fell [3];
        bit seen;
        bit go_str, go_pas, go_lap;
        int nxt;
        bit cp;
        raw = '{key_str, key_pas, key_lap};
        // A key accepted as pressed is acted on two edges later.
        go_pas = pow && m_fell2[1];
        go_str = pow && m_fell2[0] && !go_pas;
        go_lap = pow && m_fell2[2] && !go_pas && !m_fell2[0];
        nxt = m_state;
        cp  = 1'b0;
        if (!pow) begin
            nxt = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE:  if (go_str) nxt = S_RUN; else if (go_lap) cp = 1'b1;
                S_RUN:   if (go_pas) nxt = S_PAUSE; else if (go_lap) nxt = S_LAP;
                S_LAP:   if (go_pas) nxt = S_PAUSE; else if (go_lap) nxt = S_RUN;
                default: if (go_str) nxt = S_RUN; else if (go_lap) begin nxt = S_IDLE; cp = 1'b1; end
            endcase
        end
        if (m_state == S_RUN || m_state == S_LAP) m_phase = (m_phase + 1) % DIV;
        else if (m_state == S_IDLE)               m_phase = 0;
        m_state = nxt;
        m_clr   = cp;
        // Debounce: a new level is accepted after DEB consecutive differing cycles.
        for (int k = 0; k < 3; k++) begin
            seen    = m_h2[k];
            fell[k] = 1'b0;
            if (seen != m_acc[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_acc[k] = seen;
                    m_run[k] = 0;
                    fell[k]  = !seen;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_fell2 = m_fell1;
        m_fell1 = fell;
        m_h2    = m_h1;
        m_h1    = raw;
    endtask

    task automatic compare();
        bit run_now;
        run_now = (m_state == S_RUN) || (m_state == S_LAP);
        check("state",     32'(state),     32'(m_state));
        check("tick",      32'(tick),      32'(run_now && (m_phase == DIV - 1)));
        check("cnt_clr",   32'(cnt_clr),   32'(m_clr));
        check("disp_hold", 32'(disp_hold), 32'(m_state == S_LAP));
        check("run_led",   32'(run_led),   32'(run_now));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        tick_cnt += int'(tick);
        clr_cnt  += int'(cnt_clr);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic set_keys(input bit [2:0] m, input bit lvl);
        if (m[0]) key_str = lvl;
        if (m[1]) key_pas = lvl;
        if (m[2]) key_lap = lvl;
    endtask

    // Hold the masked keys low for len cycles, then release and settle.
    task automatic press(input bit [2:0] m, input int len, input int gap);
        set_keys(m, 1'b0);
        hold(len);
        set_keys(m, 1'b1);
        hold(gap);
    endtask

    task automatic async_reset_check(input string tag);
        #2 clr = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"},     32'(state),     32'd0);
        check({tag, "_tick"},      32'(tick),      32'd0);
        check({tag, "_cnt_clr"},   32'(cnt_clr),   32'd0);
        check({tag, "_disp_hold"}, 32'(disp_hold), 32'd0);
        check({tag, "_run_led"},   32'(run_led),   32'd0);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        int t_run;
        model_reset();

        // Reset state, then release with keys high and pow=1.
        #12;
        check("rst_state",   32'(state),   32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_run_led", 32'(run_led), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        hold(3);

        // 1. Start latency and tick rate.
        t_run = -1;
        key_str = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            step();
            if (t_run < 0 && state == 2'(S_RUN)) begin
                t_run    = i;
                tick_cnt = int'(tick);
            end
            if (i == 10) key_str = 1'b1;
            if (t_run > 0 && i == t_run + 19) check("ticks_20cyc", 32'(tick_cnt), 32'd4);
        end
        check("str_latency", 32'(t_run), 32'd8);

        // 2. Bounced pause is ignored; clean pause freezes; resume.
        set_keys(M_PAS, 1'b0); hold(2);
        set_keys(M_PAS, 1'b1); hold(1);
        set_keys(M_PAS, 1'b0); hold(2);
        set_keys(M_PAS, 1'b1); hold(10);
        check("bounce_run", 32'(state), 32'(S_RUN));
        hold(3);
        press(M_PAS, 8, 8);
        check("pause", 32'(state), 32'(S_PAUSE));
        tick_cnt = 0;
        hold(12);
        check("pause_no_tick", 32'(tick_cnt), 32'd0);
        press(M_STR, 8, 8);
        check("resume", 32'(state), 32'(S_RUN));

        // 3. Lap freezes display while ticks continue, second lap returns.
        press(M_LAP, 8, 2);
        check("lap_state", 32'(state), 32'(S_LAP));
        check("lap_hold",  32'(disp_hold), 32'd1);
        tick_cnt = 0;
        hold(10);
        check("lap_ticks", 32'(tick_cnt), 32'd2);
        press(M_LAP, 8, 8);
        check("unlap_state", 32'(state), 32'(S_RUN));
        check("unlap_hold",  32'(disp_hold), 32'd0);

        // 4. Reset from PAUSE and from IDLE, one clear each.
        press(M_PAS, 8, 8);
        clr_cnt = 0;
        press(M_LAP, 8, 8);
        check("clr_from_pause", 32'(clr_cnt), 32'd1);
        check("idle_after_clr", 32'(state), 32'(S_IDLE));
        clr_cnt = 0;
        press(M_LAP, 8, 8);
        check("clr_in_idle", 32'(clr_cnt), 32'd1);
        check("idle_stays",  32'(state), 32'(S_IDLE));

        // 5. Simultaneous start+pause: pause wins.
        press(M_STR, 8, 8);
        press(M_PAS, 8, 8);
        press(M_STR | M_PAS, 8, 8);
        check("both_in_pause", 32'(state), 32'(S_PAUSE));
        press(M_STR, 8, 8);
        press(M_STR | M_PAS, 8, 8);
        check("both_in_run", 32'(state), 32'(S_PAUSE));

        // Randomized key and power activity.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                pow = 1'b0;
                hold($urandom_range(1, 6));
                pow = 1'b1;
            end else if (r <= 4) begin
                hold($urandom_range(1, 10));
            end else if (r <= 8) begin
                bit [2:0] m;
                m = 3'($urandom_range(1, 7));
                set_keys(m, 1'b0); hold($urandom_range(1, 3));
                set_keys(m, 1'b1); hold($urandom_range(1, 2));
                set_keys(m, 1'b0); hold($urandom_range(1, 12));
                set_keys(m, 1'b1); hold($urandom_range(0, 9));
            end else begin
                press(3'($urandom_range(1, 7)), $urandom_range(1, 12), $urandom_range(0, 10));
            end
        end
        pow = 1'b1;
        hold(10);

        // 6. Power drop during LAP, start ignored without power, async reset.
        async_reset_check("rst_mid");
        hold(2);
        press(M_STR, 8, 8);
        press(M_LAP, 8, 2);
        check("lap_before_pow", 32'(state), 32'(S_LAP));
        pow = 1'b0;
        step();
        check("pow_idle",      32'(state),     32'(S_IDLE));
        check("pow_disp_hold", 32'(disp_hold), 32'd0);
        check("pow_cnt_clr",   32'(cnt_clr),   32'd0);
        clr_cnt = 0;
        press(M_STR, 8, 8);
        check("pow_str_ignored", 32'(state), 32'(S_IDLE));
        check("pow_no_clr",      32'(clr_cnt), 32'd0);
        pow = 1'b1;
        hold(2);
        press(M_STR, 8, 3);
        check("run_before_rst", 32'(state), 32'(S_RUN));
        async_reset_check("rst_run");
        hold(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control front-end for the 6-digit stopwatch counter/display datapath.
- Debounces three active-low pushbuttons and turns them into single-cycle press events.
- Runs the start/pause/lap/reset state machine.
- Generates the centisecond count-enable tick, the counter clear pulse and the display-freeze (lap) select. The existing counter then increments only on `tick`.

Parameters:
- DIV, 500000: clk cycles per tick (10 ms at 50 MHz); legal range ≥2.
- DEB, 1000000: consecutive stable cycles required to accept a button level change (20 ms); legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- pow  in  1  power/enable switch; low forces IDLE.
- key_str  in  1  start button, active-low, asynchronous.
- key_pas  in  1  pause button, active-low, asynchronous.
- key_lap  in  1  lap/reset button, active-low, asynchronous.
- tick  out  1  one-cycle count enable for the counter.
- cnt_clr  out  1  one-cycle synchronous clear for the counter.
- disp_hold  out  1  1 = display shows the latched lap value; 0 = live count.
- state  out  2  00 IDLE, 01 RUN, 10 LAP, 11 PAUSE.
- run_led  out  1  1 in RUN or LAP.

Behaviour:

Reset (clr low, asynchronous):
- state=IDLE; tick, cnt_clr, disp_hold and run_led = 0.
- Prescaler = 0; debounce counters = 0.
- Debounced levels = 1 (released); synchronizer flops = 1.

Button path (per key):
- 2-flop synchronizer feeds a debounce counter.
- While the synced level ≠ debounced level, the counter increments. Any cycle the two are equal, the counter resets to 0.
- When the counter reaches DEB-1 and the levels still differ, the debounced level takes the synced value and the counter resets.
- Press event = debounced 1→0 transition, registered as a 1-cycle pulse (p_str, p_pas, p_lap).
- Release generates no event; holding a button generates exactly one event.

Event priority:
- When several press events occur in the same cycle, only the highest-priority one is acted on: pas > str > lap.
- Lower-priority events in that cycle are discarded.

FSM (registered; transitions take effect the cycle after the event):
- IDLE:
  - p_str && pow → RUN.
  - p_lap → cnt_clr=1 for one cycle, stay IDLE.
- RUN:
  - p_pas → PAUSE.
  - p_lap → LAP, disp_hold=1.
  - p_str ignored.
- LAP (counter keeps running, display frozen):
  - p_lap → RUN, disp_hold=0.
  - p_pas → PAUSE, disp_hold=0.
  - p_str ignored.
- PAUSE:
  - p_str && pow → RUN.
  - p_lap → IDLE with cnt_clr=1 for one cycle.
- Any state, pow=0 → IDLE next cycle. No cnt_clr; disp_hold=0; button events ignored while pow=0.

Prescaler:
- Width = clog2(DIV).
- Counts only when state is RUN or LAP; tick=1 during the cycle the prescaler equals DIV-1, and the prescaler then wraps to 0.
- Holds its value in PAUSE, so a resumed count completes the partial tick.
- Forced to 0 in IDLE and on any cycle with cnt_clr=1.
- tick is never asserted in IDLE or PAUSE, including in the cycle the state leaves RUN/LAP (tick is decoded from the registered state).

Outputs:
- All outputs are registered or decoded from the registered state; no combinational path from the keys.
- run_led = (state==RUN || state==LAP).

Latency:
- Key edge to press event = 2 (sync) + DEB + 1 cycles.
- Press event to state change = 1 cycle.

Test Plan (DIV=5, DEB=4):
1. Release clr with keys high and pow=1, pulse key_str low for 10 cycles → state 01 exactly 2+4+1+1 cycles after the falling edge. Then tick pulses every 5 cycles; 20 cycles in RUN → exactly 4 ticks.
2. Bounce key_pas (low 2 cycles, high 1, low 2, high) → no event, state stays RUN. Then a clean 8-cycle press → PAUSE. Prescaler value is frozen in PAUSE (e.g. 3 from 3 cycles into a tick period). After p_str, the first tick comes 1 cycle into RUN (prescaler 3→4).
3. In RUN, press key_lap → state 10, disp_hold=1, ticks continue. Press key_lap again → state 01, disp_hold=0.
4. From PAUSE, press key_lap → exactly one cnt_clr pulse, state 00, prescaler 0. Press key_lap in IDLE → another single cnt_clr, state stays 00.
5. Press key_str and key_pas simultaneously (identical waveforms) while in PAUSE → pas wins, state stays 11. Repeat from RUN → PAUSE.
6. Drop pow during LAP → IDLE next cycle, disp_hold=0, no cnt_clr. Press key_str with pow=0 → stays IDLE. Assert clr mid-RUN → all outputs 0 asynchronously, state 00.
